fir_tap_accumulator: RTL and testbench

//   Sequential accumulation stage for the FIR datapath. It sits directly downstream of the tap multiplier.
//   Per output sample, it takes TAPS signed products, one per valid/ready handshake.

---
 rtl/fir_tap_accumulator.sv | 162 ++++++++++++++++
 tb/tb_fir_tap_accumulator.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fir_tap_accumulator.sv
// Accumulates TAPS signed products per output sample through a ripple-carry adder
// and presents the wrapped ACC_W-bit result with a sticky signed-overflow flag.

module fir_rca #(
    parameter int W = 20
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W-1:0] sum_o
);
    logic [W-1:0] carry_s;

    assign carry_s[0] = cin_i;

    // The final stage produces no carry-out: the result wraps modulo 2^W.
    for (genvar i = 0; i < W; i++) begin : g_bit
        assign sum_o[i] = a_i[i] ^ b_i[i] ^ carry_s[i];
        if (i < W - 1) begin : g_carry
            assign carry_s[i+1] = (a_i[i] & b_i[i]) | (carry_s[i] & (a_i[i] ^ b_i[i]));
        end
    end
endmodule

module fir_tap_accumulator #(
    parameter int N     = 16,
    parameter int TAPS  = 8,
    parameter int ACC_W = 20,
    localparam int CNT_W = $clog2(TAPS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             prod_valid,
    input  logic [N-1:0]     prod_data,
    output logic             prod_ready,
    output logic             sum_valid,
    output logic [ACC_W-1:0] sum_data,
    input  logic             sum_ready,
    output logic             ovf,
    output logic [CNT_W-1:0] tap_cnt
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(TAPS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               sum_valid_q, sum_valid_d;
    logic               prod_ready_q, prod_ready_d;

    logic [ACC_W-1:0]   prod_sext_s;
    logic [ACC_W-1:0]   add_sum_s;
    logic               add_ovf_s;
    logic               accept_s;

    // Sign-extend the incoming product to accumulator width.
    always_comb begin
        prod_sext_s        = {ACC_W{prod_data[N-1]}};
        prod_sext_s[N-1:0] = prod_data;
    end

    fir_rca #(.W(ACC_W)) u_rca (
        .a_i   (acc_q),
        .b_i   (prod_sext_s),
        .cin_i (1'b0),
        .sum_o (add_sum_s)
    );

    assign add_ovf_s = (acc_q[ACC_W-1] == prod_sext_s[ACC_W-1]) &&
                       (add_sum_s[ACC_W-1] != acc_q[ACC_W-1]);
    assign accept_s  = prod_valid && prod_ready_q;

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        if (clear) begin
            state_d = ST_IDLE;
            acc_d   = {ACC_W{1'b0}};
            cnt_d   = {CNT_W{1'b0}};
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        acc_d   = prod_sext_s;
                        cnt_d   = CNT_ONE;
                        ovf_d   = 1'b0;
                        state_d = ST_ACCUM;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ACCUM: begin
                    if (accept_s) begin
                        acc_d = add_sum_s;
                        cnt_d = cnt_q + CNT_ONE;
                        ovf_d = ovf_q | add_ovf_s;
                        if (cnt_q == LAST_TAP) begin
                            state_d = ST_HOLD;
                        end else begin
                            state_d = ST_ACCUM;
                        end
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end
                ST_HOLD: begin
                    if (sum_valid_q && sum_ready) begin
                        state_d = ST_IDLE;
                        cnt_d   = {CNT_W{1'b0}};
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    acc_d   = {ACC_W{1'b0}};
                    cnt_d   = {CNT_W{1'b0}};
                    ovf_d   = 1'b0;
                end
            endcase
        end
        sum_valid_d  = (state_d == ST_HOLD);
        prod_ready_d = (state_d != ST_HOLD);
    end

    // State and output registers; prod_ready stays low until the first edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            acc_q        <= {ACC_W{1'b0}};
            cnt_q        <= {CNT_W{1'b0}};
            ovf_q        <= 1'b0;
            sum_valid_q  <= 1'b0;
            prod_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            ovf_q        <= ovf_d;
            sum_valid_q  <= sum_valid_d;
            prod_ready_q <= prod_ready_d;
        end
    end

    assign prod_ready = prod_ready_q;
    assign sum_valid  = sum_valid_q;
    assign sum_data   = acc_q;
    assign ovf        = ovf_q;
    assign tap_cnt    = cnt_q;
endmodule

// File: tb/tb_fir_tap_accumulator.sv
// Randomized/directed bench: a 20-bit and a 16-bit accumulator share one stimulus
// stream and are checked against an arithmetic model of the frame sum and overflow.

module tb_fir_tap_accumulator;
    localparam int TAPS = 8;

    logic clk = 1'b0;
    logic rst_n, clear, prod_valid, sum_ready;
    logic [15:0] prod_data;

    logic               pr20, sv20, ovf20, pr16, sv16, ovf16;
    logic signed [19:0] sd20;
    logic signed [15:0] sd16;
    logic [3:0]         tc20, tc16;

    int vecs    = 0;
    int miscmp  = 0;
    int n       = 0;
    longint m_acc20, m_acc16;
    bit     m_ovf20, m_ovf16;

    always #5 clk = ~clk;

    fir_tap_accumulator #(.N(16), .TAPS(TAPS), .ACC_W(20)) dut20 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .prod_valid(prod_valid),
        .prod_data(prod_data), .prod_ready(pr20), .sum_valid(sv20),
        .sum_data(sd20), .sum_ready(sum_ready), .ovf(ovf20), .tap_cnt(tc20));

    fir_tap_accumulator #(.N(16), .TAPS(TAPS), .ACC_W(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .prod_valid(prod_valid),
        .prod_data(prod_data), .prod_ready(pr16), .sum_valid(sv16),
        .sum_data(sd16), .sum_ready(sum_ready), .ovf(ovf16), .tap_cnt(tc16));

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miscmp++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Exact-integer frame sum: any step leaving the w-bit signed range sets ovf.
    task automatic madd(input longint p, input int w, inout longint acc, inout bit ov);
        longint e, lim;
        lim = 64'sd1 <<< (w - 1);
        if (n == 0) begin
            acc = p;
            ov  = 1'b0;
        end else begin
            e = acc + p;
            if (e >= lim || e < -lim) ov = 1'b1;
            if (e >= lim) e = e - 2 * lim;
            else if (e < -lim) e = e + 2 * lim;
            acc = e;
        end
    endtask

    task automatic push(input logic [15:0] p, input int gap);
        longint ps;
        for (int g = 0; g < gap; g++) begin
            prod_valid = 1'b0;
            prod_data  = 16'($urandom);
            sum_ready  = 1'($urandom);
            @(posedge clk); #1;
            chk("stall_tap_cnt", tc20, n);
        end
        chk("ready20_before_accept", pr20, 1);
        chk("ready16_before_accept", pr16, 1);
        prod_valid = 1'b1;
        prod_data  = p;
        @(posedge clk); #1;
        prod_valid = 1'b0;
        ps = longint'($signed(p));
        madd(ps, 20, m_acc20, m_ovf20);
        madd(ps, 16, m_acc16, m_ovf16);
        n++;
        chk("tap_cnt20", tc20, n);
        chk("tap_cnt16", tc16, n);
        chk("sum_valid_latency", sv20, (n == TAPS) ? 1 : 0);
    endtask

    task automatic collect(input int hold);
        chk("sum_valid20", sv20, 1);
        chk("sum_valid16", sv16, 1);
        chk("sum_data20", sd20, m_acc20);
        chk("sum_data16", sd16, m_acc16);
        chk("ovf20", ovf20, m_ovf20);
        chk("ovf16", ovf16, m_ovf16);
        chk("hold_ready", pr20, 0);
        for (int h = 0; h < hold; h++) begin
            sum_ready = 1'b0;
            @(posedge clk); #1;
            chk("hold_valid", sv20, 1);
            chk("hold_data", sd20, m_acc20);
            chk("hold_ovf16", ovf16, m_ovf16);
            chk("hold_ready_low", pr20, 0);
        end
        sum_ready = 1'b1;
        @(posedge clk); #1;
        sum_ready = 1'b0;
        n = 0;
        chk("release_valid", sv20, 0);
        chk("release_tap_cnt", tc20, 0);
        chk("release_ready", pr20, 1);
    endtask

    task automatic random_frame(input int maxgap);
        for (int i = 0; i < TAPS; i++) push(16'($urandom), $urandom_range(0, maxgap));
    endtask

    initial begin
        logic [15:0] t2 [8];
        rst_n = 1'b0; clear = 1'b0; prod_valid = 1'b0; sum_ready = 1'b0; prod_data = 16'h0000;
        #12;
        chk("rst_ready", pr20, 0);
        chk("rst_valid", sv20, 0);
        chk("rst_tap_cnt", tc20, 0);
        chk("rst_ovf", ovf20, 0);
        #11 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_ready", pr20, 1);

        // Back-to-back +1 products, next frame starts immediately after handshake
        for (int i = 0; i < TAPS; i++) push(16'd1, 0);
        chk("t1_sum_const", sd20, 8);
        chk("t1_ovf_const", ovf20, 0);
        collect(0);
        for (int i = 0; i < TAPS; i++) push(16'd1, 0);
        collect(0);

        // Mixed-sign products summing to zero with random stalls
        t2 = '{16'd100, 16'hFFCE, 16'hFFCE, 16'd7, 16'd0, 16'd0, 16'd0, 16'hFFF9};
        for (int i = 0; i < TAPS; i++) push(t2[i], $urandom_range(0, 3));
        chk("t2_sum_zero", sd20, 0);
        collect(2);

        // Positive overflow in the 16-bit instance wraps to 0xFFF8
        for (int i = 0; i < TAPS; i++) push(16'h7FFF, 0);
        chk("t3_sum16_wrap", sd16, -8);
        chk("t3_ovf16", ovf16, 1);
        chk("t3_ovf20", ovf20, 0);
        collect(1);
        for (int i = 0; i < TAPS; i++) push(16'd0, $urandom_range(0, 2));
        chk("t3_zero_ovf16", ovf16, 0);
        collect(0);

        // Consumer back-pressure
        random_frame(2);
        collect(5);

        // clear after three accepts with a concurrent valid product
        for (int i = 0; i < 3; i++) push(16'($urandom), 0);
        clear = 1'b1; prod_valid = 1'b1; prod_data = 16'($urandom); sum_ready = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0; prod_valid = 1'b0; sum_ready = 1'b0;
        n = 0;
        chk("clear_tap_cnt", tc20, 0);
        chk("clear_valid", sv20, 0);
        chk("clear_ready", pr20, 1);
        random_frame(1);
        collect(1);

        // clear in HOLD discards a pending handshake
        random_frame(0);
        clear = 1'b1; sum_ready = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0; sum_ready = 1'b0;
        n = 0;
        chk("clear_hold_valid", sv20, 0);
        chk("clear_hold_tap_cnt", tc20, 0);

        // Asynchronous reset mid-cycle while holding a result
        random_frame(1);
        #3 rst_n = 1'b0;
        #1;
        n = 0;
        chk("arst_valid", sv20, 0);
        chk("arst_tap_cnt", tc20, 0);
        chk("arst_ready", pr20, 0);
        #12 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("arst_release_ready", pr20, 1);
        for (int i = 0; i < 3; i++) begin
            sum_ready = 1'b1;
            @(posedge clk); #1;
            chk("no_stale_valid", sv20, 0);
        end
        sum_ready = 1'b0;

        // Randomized frames
        for (int f = 0; f < 6; f++) begin
            random_frame(3);
            collect($urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
        $finish;
    end
endmodule
